// File: rtl/sao_offset_emit.sv
// SAO offset syntax emitter: snapshots one component's offsets at start, then emits TYPE/ABS/SIGN/BAND|CLASS.
// First element is presented one cycle after start; one element per cycle while syn_ready is high, held stable on stall.
module sao_offset_emit #(
   parameter int offset_len    = 4,
   parameter int n_category    = 4,
   parameter int n_eo_type     = 4,
   parameter int n_category_bo = 32,
   parameter int n_offset      = 4
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  cIdx,
   input  logic [1:0]  type_idx,
   input  logic [1:0]  eo_class,
   input  logic [4:0]  band_pos,
   input  logic signed [0:1][0:n_eo_type-1][0:n_category-1][offset_len-1:0] offset_eo,
   input  logic signed [0:1][0:n_category_bo-1][offset_len-1:0]             offset_bo,
   output logic        syn_valid,
   input  logic        syn_ready,
   output logic [2:0]  syn_kind,
   output logic [4:0]  syn_value,
   output logic        syn_last,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE, S_TYPE, S_ABS, S_SIGN, S_BAND, S_CLASS, S_DONE
   } state_t;

   localparam int kw = (n_offset > 1) ? $clog2(n_offset) : 1;
   localparam logic [kw-1:0] K_LAST = kw'(n_offset - 1);
   localparam logic [1:0] T_OFF = 2'd0;
   localparam logic [1:0] T_BO  = 2'd1;
   localparam logic [1:0] T_EO  = 2'd2;
   localparam logic [2:0] K_TYPE  = 3'd0;
   localparam logic [2:0] K_ABS   = 3'd1;
   localparam logic [2:0] K_SIGN  = 3'd2;
   localparam logic [2:0] K_BAND  = 3'd3;
   localparam logic [2:0] K_CLASS = 3'd4;

   state_t                 state_q, state_d;
   logic [kw-1:0]          k_q, k_d;
   logic [1:0]             cidx_q, type_q, class_q;
   logic [4:0]             band_q;
   logic [offset_len-1:0]  off_q [n_offset];
   logic [offset_len-1:0]  snap  [n_offset];
   logic signed [offset_len:0] mag_v [n_offset];
   logic [2:0]             abs_v [n_offset];
   logic [n_offset-1:0]    sign_v, nz_v;
   logic [1:0]             type_n;
   logic                   accept;
   logic                   first_found, next_found;
   logic [kw-1:0]          first_idx, next_idx;

   assign type_n = (type_idx == 2'd3) ? T_OFF : type_idx;
   assign accept = (state_q == S_IDLE) && start;
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);

   // BO bands wrap modulo 32 through the 5-bit index add
   always_comb begin
      for (int k = 0; k < n_offset; k++) begin
         if (type_n == T_BO) snap[k] = offset_bo[cIdx[1]][band_pos + 5'(k)];
         else                snap[k] = offset_eo[cIdx[1]][eo_class][kw'(k)];
      end
   end

   always_comb begin
      for (int k = 0; k < n_offset; k++) begin
         mag_v[k] = $signed({off_q[k][offset_len-1], off_q[k]});
         if (mag_v[k] < 0) mag_v[k] = -mag_v[k];
         abs_v[k]  = (mag_v[k] > $signed((offset_len+1)'(7))) ? 3'd7 : mag_v[k][2:0];
         sign_v[k] = off_q[k][offset_len-1];
         nz_v[k]   = (abs_v[k] != 3'd0);
      end
   end

   // Lowest nonzero-abs index overall and above k_q; lets SIGN skip zeros without idle cycles
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      for (int k = n_offset - 1; k >= 0; k--) begin
         if (nz_v[k]) begin
            first_found = 1'b1;
            first_idx   = kw'(k);
         end
         if (nz_v[k] && (k > int'(k_q))) begin
            next_found = 1'b1;
            next_idx   = kw'(k);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      syn_valid = 1'b0;
      syn_kind  = 3'd0;
      syn_value = 5'd0;
      syn_last  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d = '0;
               if (cIdx != 2'd2)         state_d = S_TYPE;
               else if (type_n == T_OFF) state_d = S_DONE;
               else                      state_d = S_ABS;
            end
         end
         S_TYPE: begin
            syn_valid = 1'b1;
            syn_kind  = K_TYPE;
            syn_value = {3'b000, type_q};
            syn_last  = (type_q == T_OFF);
            if (syn_ready) state_d = (type_q == T_OFF) ? S_DONE : S_ABS;
         end
         S_ABS: begin
            syn_valid = 1'b1;
            syn_kind  = K_ABS;
            syn_value = {2'b00, abs_v[k_q]};
            syn_last  = (type_q == T_EO) && (cidx_q == 2'd2) && (k_q == K_LAST);
            if (syn_ready) begin
               if (k_q != K_LAST) begin
                  k_d = k_q + kw'(1);
               end else if (type_q == T_BO) begin
                  if (first_found) begin
                     state_d = S_SIGN;
                     k_d     = first_idx;
                  end else begin
                     state_d = S_BAND;
                  end
               end else begin
                  state_d = (cidx_q != 2'd2) ? S_CLASS : S_DONE;
               end
            end
         end
         S_SIGN: begin
            syn_valid = 1'b1;
            syn_kind  = K_SIGN;
            syn_value = {4'b0000, sign_v[k_q]};
            if (syn_ready) begin
               if (next_found) k_d = next_idx;
               else            state_d = S_BAND;
            end
         end
         S_BAND: begin
            syn_valid = 1'b1;
            syn_kind  = K_BAND;
            syn_value = band_q;
            syn_last  = 1'b1;
            if (syn_ready) state_d = S_DONE;
         end
         S_CLASS: begin
            syn_valid = 1'b1;
            syn_kind  = K_CLASS;
            syn_value = {3'b000, class_q};
            syn_last  = 1'b1;
            if (syn_ready) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cidx_q  <= '0;
         type_q  <= '0;
         class_q <= '0;
         band_q  <= '0;
         for (int k = 0; k < n_offset; k++) off_q[k] <= '0;
      end else if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cidx_q  <= '0;
         type_q  <= '0;
         class_q <= '0;
         band_q  <= '0;
         for (int k = 0; k < n_offset; k++) off_q[k] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (accept) begin
            cidx_q  <= cIdx;
            type_q  <= type_n;
            class_q <= eo_class;
            band_q  <= band_pos;
            for (int k = 0; k < n_offset; k++) off_q[k] <= snap[k];
         end
      end
   end

endmodule

// File: tb/tb_sao_offset_emit.sv
// Bench for sao_offset_emit: directed streams plus randomized components against a spec-level stream model.
module tb_sao_offset_emit;

   logic        clk = 1'b0;
   logic        arst_n, rst_n, start, syn_ready;
   logic [1:0]  cIdx, type_idx, eo_class;
   logic [4:0]  band_pos;
   logic signed [0:1][0:3][0:3][3:0] offset_eo;
   logic signed [0:1][0:31][3:0]     offset_bo;
   logic        syn_valid, syn_last, busy, done;
   logic [2:0]  syn_kind;
   logic [4:0]  syn_value;

   int n_vec = 0;
   int n_err = 0;
   int tbl_eo [2][4][4];
   int tbl_bo [2][32];
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int done_cyc, last_cyc, viol;
   logic valid_at_start, valid_first, busy_first, busy_after;

   always #5 clk = ~clk;

   sao_offset_emit dut (
      .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .start(start),
      .cIdx(cIdx), .type_idx(type_idx), .eo_class(eo_class), .band_pos(band_pos),
      .offset_eo(offset_eo), .offset_bo(offset_bo),
      .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_kind(syn_kind),
      .syn_value(syn_value), .syn_last(syn_last), .busy(busy), .done(done)
   );

   function automatic logic [8:0] el(input int kind, input int val, input bit last);
      return {3'(kind), 5'(val), last};
   endfunction

   // Expected element stream of one component, built from the syntax rules on the current tables
   function automatic void model(input logic [1:0] c, input logic [1:0] t, input logic [1:0] e,
                                 input logic [4:0] b);
      int tt;
      int o[4];
      int a[4];
      exp_q.delete();
      tt = (t == 2'd3) ? 0 : int'(t);
      for (int k = 0; k < 4; k++) begin
         o[k] = (tt == 1) ? tbl_bo[c[1]][(int'(b) + k) % 32] : tbl_eo[c[1]][e][k];
         a[k] = (o[k] < 0) ? -o[k] : o[k];
         if (a[k] > 7) a[k] = 7;
      end
      if (c != 2'd2) exp_q.push_back(el(0, tt, tt == 0));
      if (tt == 0) return;
      for (int k = 0; k < 4; k++) exp_q.push_back(el(1, a[k], (tt == 2) && (c == 2'd2) && (k == 3)));
      if (tt == 1) begin
         for (int k = 0; k < 4; k++) if (a[k] != 0) exp_q.push_back(el(2, (o[k] < 0) ? 1 : 0, 0));
         exp_q.push_back(el(3, int'(b), 1));
      end else if (c != 2'd2) begin
         exp_q.push_back(el(4, int'(e), 1));
      end
   endfunction

   task automatic load_tables();
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) offset_eo[1'(i)][2'(j)][2'(k)] = 4'(tbl_eo[i][j][k]);
         for (int j = 0; j < 32; j++) offset_bo[1'(i)][5'(j)] = 4'(tbl_bo[i][j]);
      end
   endtask

   task automatic random_tables();
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) tbl_eo[i][j][k] = int'($urandom_range(0, 15)) - 8;
         for (int j = 0; j < 32; j++) tbl_bo[i][j] = int'($urandom_range(0, 15)) - 8;
      end
      load_tables();
   endtask

   // Drives one start and records every transferred element, stall stability and done/busy timing
   task automatic run_comp(input logic [1:0] c, input logic [1:0] t, input logic [1:0] e,
                           input logic [4:0] b, input int rmode, input bit disturb, input bit nowait);
      logic [8:0] held_v, cur;
      bit held;
      got_q.delete();
      viol = 0; done_cyc = -1; last_cyc = -1; held = 0; held_v = '0;
      if (!nowait) @(negedge clk);
      cIdx = c; type_idx = t; eo_class = e; band_pos = b; start = 1'b1; syn_ready = 1'b1;
      valid_at_start = syn_valid;
      @(negedge clk);
      start = 1'b0;
      valid_first = syn_valid;
      busy_first  = busy;
      for (int cyc = 1; cyc < 300; cyc++) begin
         case (rmode)
            0:       syn_ready = 1'b1;
            1:       syn_ready = ((cyc % 4) == 1) || ((cyc % 4) == 0);
            default: syn_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (disturb && cyc == 2) begin
            for (int i = 0; i < 2; i++) begin
               for (int j = 0; j < 4; j++)
                  for (int k = 0; k < 4; k++) tbl_eo[i][j][k] = -tbl_eo[i][j][k] - 1;
               for (int j = 0; j < 32; j++) tbl_bo[i][j] = -tbl_bo[i][j] - 1;
            end
            load_tables();
            start = 1'b1; cIdx = 2'd2; type_idx = 2'd2; eo_class = ~e; band_pos = ~b;
         end
         if (disturb && cyc == 3) start = 1'b0;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         cur = {syn_kind, syn_value, syn_last};
         if (syn_valid) begin
            if (held && cur !== held_v) viol++;
            if (syn_ready) begin
               got_q.push_back(cur);
               last_cyc = cyc;
               held = 0;
            end else begin
               held = 1;
               held_v = cur;
            end
         end else if (held) begin
            viol++;
         end
         @(negedge clk);
      end
      @(negedge clk);
      busy_after = busy;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({syn_valid, syn_kind, syn_value, syn_last, busy, done} !== 12'b0) begin
         n_err++;
         $display("FAIL reset_async outputs got %b exp 0", {syn_valid, syn_kind, syn_value, syn_last, busy, done});
      end
      arst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({syn_valid, busy, done} !== 3'b0) begin
         n_err++;
         $display("FAIL reset_release idle got %b exp 000", {syn_valid, busy, done});
      end
   endtask

   task automatic test_bo_wrap();
      random_tables();
      tbl_bo[0][30] = 3; tbl_bo[0][31] = -2; tbl_bo[0][0] = 0; tbl_bo[0][1] = -8;
      load_tables();
      exp_q = '{el(0,1,0), el(1,3,0), el(1,2,0), el(1,0,0), el(1,7,0),
                el(2,0,0), el(2,1,0), el(2,1,0), el(3,30,1)};
      run_comp(2'd0, 2'd1, 2'd0, 5'd30, 0, 0, 0);
      n_vec++;
      if (valid_at_start !== 1'b0 || valid_first !== 1'b1 || busy_first !== 1'b1) begin
         n_err++;
         $display("FAIL bo_wrap start_timing got v0=%b v1=%b busy=%b exp 0 1 1", valid_at_start, valid_first, busy_first);
      end
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL bo_wrap count got %0d exp %0d", got_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_vec++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL bo_wrap elem %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
      n_vec++;
      if (done_cyc != 10 || busy_after !== 1'b0) begin
         n_err++;
         $display("FAIL bo_wrap done_timing got cyc=%0d busy_after=%b exp 10 0", done_cyc, busy_after);
      end
   endtask

   task automatic test_eo();
      random_tables();
      tbl_eo[0][2] = '{1, 0, 0, -4};
      tbl_eo[1][1] = '{2, 1, -1, -3};
      load_tables();
      exp_q = '{el(0,2,0), el(1,1,0), el(1,0,0), el(1,0,0), el(1,4,0), el(4,2,1)};
      run_comp(2'd1, 2'd2, 2'd2, 5'd9, 0, 0, 0);
      n_vec++;
      if (got_q.size() != exp_q.size() || done_cyc != 7) begin
         n_err++;
         $display("FAIL eo_cb count got %0d done %0d exp %0d done 7", got_q.size(), done_cyc, exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_vec++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL eo_cb elem %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
      exp_q = '{el(1,2,0), el(1,1,0), el(1,1,0), el(1,3,1)};
      run_comp(2'd2, 2'd2, 2'd1, 5'd3, 0, 0, 0);
      n_vec++;
      if (got_q.size() != exp_q.size() || done_cyc != 5) begin
         n_err++;
         $display("FAIL eo_cr count got %0d done %0d exp %0d done 5", got_q.size(), done_cyc, exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_vec++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL eo_cr elem %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
   endtask

   task automatic test_type_off();
      logic [1:0] tv;
      for (int r = 0; r < 2; r++) begin
         tv = (r == 0) ? 2'd0 : 2'd3;
         run_comp(2'd2, tv, 2'd1, 5'd4, 0, 0, 0);
         n_vec++;
         if (got_q.size() != 0 || valid_first !== 1'b0 || done_cyc != 1 || busy_after !== 1'b0) begin
            n_err++;
            $display("FAIL cr_off t=%0d got n=%0d v=%b done=%0d busy_after=%b exp 0 0 1 0",
                     tv, got_q.size(), valid_first, done_cyc, busy_after);
         end
         run_comp(2'd0, tv, 2'd1, 5'd4, 0, 0, 0);
         n_vec++;
         if (got_q.size() != 1 || got_q[0] !== el(0,0,1) || done_cyc != 2) begin
            n_err++;
            $display("FAIL y_off t=%0d got n=%0d e0=%h done=%0d exp 1 %h 2",
                     tv, got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h1ff, done_cyc, el(0,0,1));
         end
      end
   endtask

   task automatic test_stall();
      random_tables();
      tbl_bo[0][12] = -5; tbl_bo[0][14] = 6;
      load_tables();
      model(2'd0, 2'd1, 2'd0, 5'd12);
      run_comp(2'd0, 2'd1, 2'd0, 5'd12, 1, 1, 0);
      n_vec++;
      if (viol != 0) begin
         n_err++;
         $display("FAIL stall_hold violations got %0d exp 0", viol);
      end
      n_vec++;
      if (got_q.size() != exp_q.size() || done_cyc != last_cyc + 1 || busy_after !== 1'b0) begin
         n_err++;
         $display("FAIL stall_count got n=%0d done=%0d last=%0d busy_after=%b exp n=%0d done=last+1",
                  got_q.size(), done_cyc, last_cyc, busy_after, exp_q.size());
      end
      foreach (exp_q[i]) begin
         n_vec++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL stall_elem %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      random_tables();
      model(2'd1, 2'd2, 2'd3, 5'd0);
      run_comp(2'd1, 2'd2, 2'd3, 5'd0, 0, 0, 0);
      model(2'd0, 2'd1, 2'd0, 5'd31);
      run_comp(2'd0, 2'd1, 2'd0, 5'd31, 0, 0, 1);
      n_vec++;
      if (valid_first !== 1'b1 || got_q.size() != exp_q.size() || done_cyc != exp_q.size() + 1) begin
         n_err++;
         $display("FAIL b2b restart got v=%b n=%0d done=%0d exp 1 %0d %0d",
                  valid_first, got_q.size(), done_cyc, exp_q.size(), exp_q.size() + 1);
      end
      foreach (exp_q[i]) begin
         n_vec++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL b2b elem %0d got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      for (int r = 0; r < 2; r++) begin
         random_tables();
         @(negedge clk);
         cIdx = 2'd0; type_idx = 2'd1; eo_class = 2'd0; band_pos = 5'd7; start = 1'b1; syn_ready = 1'b1;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
         n_vec++;
         if (!(syn_valid === 1'b1 && syn_kind === 3'd1)) begin
            n_err++;
            $display("FAIL reset_mid in_abs got v=%b kind=%0d exp 1 1", syn_valid, syn_kind);
         end
         if (r == 0) begin
            #2 arst_n = 1'b0;
            #1;
         end else begin
            rst_n = 1'b0;
            @(negedge clk);
         end
         n_vec++;
         if ({syn_valid, syn_kind, syn_value, syn_last, busy, done} !== 12'b0) begin
            n_err++;
            $display("FAIL reset_mid r=%0d outputs got %b exp 0", r,
                     {syn_valid, syn_kind, syn_value, syn_last, busy, done});
         end
         @(negedge clk);
         arst_n = 1'b1; rst_n = 1'b1;
         seen = 0;
         repeat (4) begin
            @(negedge clk);
            if (done || syn_valid || busy) seen = 1;
         end
         n_vec++;
         if (seen) begin
            n_err++;
            $display("FAIL reset_mid r=%0d abandoned got activity=1 exp 0", r);
         end
         model(2'd0, 2'd1, 2'd0, 5'd7);
         run_comp(2'd0, 2'd1, 2'd0, 5'd7, 0, 0, 0);
         n_vec++;
         if (got_q.size() != exp_q.size() || got_q.size() == 0 || got_q[0][8:6] !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid r=%0d fresh got n=%0d exp n=%0d starting with TYPE", r, got_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) begin
            n_vec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL reset_mid r=%0d elem %0d got %h exp %h", r, i,
                        (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] c, t, e;
      logic [4:0] b;
      for (int n = 0; n < 40; n++) begin
         random_tables();
         c = 2'($urandom_range(0, 2));
         t = 2'($urandom_range(0, 3));
         e = 2'($urandom_range(0, 3));
         b = 5'($urandom_range(0, 31));
         model(c, t, e, b);
         run_comp(c, t, e, b, 2, 0, 0);
         n_vec++;
         if (viol != 0 || busy_first !== 1'b1 || busy_after !== 1'b0 ||
             done_cyc != ((exp_q.size() == 0) ? 1 : last_cyc + 1)) begin
            n_err++;
            $display("FAIL rand %0d ctrl got viol=%0d busy=%b/%b done=%0d last=%0d", n, viol,
                     busy_first, busy_after, done_cyc, last_cyc);
         end
         n_vec++;
         if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand %0d count got %0d exp %0d (c=%0d t=%0d)", n, got_q.size(), exp_q.size(), c, t);
         end
         foreach (exp_q[i]) begin
            n_vec++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL rand %0d elem %0d got %h exp %h", n, i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      arst_n = 1'b0; rst_n = 1'b1; start = 1'b0; syn_ready = 1'b0;
      cIdx = 2'd0; type_idx = 2'd0; eo_class = 2'd0; band_pos = 5'd0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) tbl_eo[i][j][k] = 0;
         for (int j = 0; j < 32; j++) tbl_bo[i][j] = 0;
      end
      load_tables();
      test_reset();
      test_bo_wrap();
      test_eo();
      test_type_off();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
